// File: rtl/alu_dec_stage_if.sv
// alu_dec_stage_if
// Handshake and control bus between the decode stage and its neighbours.
//   Upstream side : in_valid, in_ready, op, funct3, funct7b5
//   Downstream    : out_valid, out_ready, alu_control, alu_src_b, illegal
// Modports:
//   slave  - the decode stage itself (consumes the instruction, produces control)
//   master - the environment driving instructions and consuming control
interface alu_dec_stage_if;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] alu_control;
    logic       alu_src_b;
    logic       illegal;

    modport slave (
        input  in_valid, op, funct3, funct7b5, out_ready,
        output in_ready, out_valid, alu_control, alu_src_b, illegal
    );

    modport master (
        output in_valid, op, funct3, funct7b5, out_ready,
        input  in_ready, out_valid, alu_control, alu_src_b, illegal
    );
endinterface

// File: rtl/alu_dec_stage.sv
// alu_dec_stage
// ID/EX control stage: decodes op/funct3/funct7b5 into the 3-bit ALU control
// word, the B-operand select and an illegal flag, and holds the result behind
// a valid/ready handshake so the execute stage can stall it.
// Ports:
//   clk          - clock, all state updates on the rising edge
//   rst_n        - synchronous active-low reset
//   flush        - drops every held entry and the input of the same cycle
//   bus          - alu_dec_stage_if.slave (instruction in, control out)
//   illegal_cnt  - saturating count of illegal entries delivered
// Build option:
//   ALU_DEC_SKID_EN defined   - main register plus one-entry skid buffer,
//                               in_ready comes straight from a flop.
//   ALU_DEC_SKID_EN undefined - single register, in_ready = ~out_valid | out_ready.
module alu_dec_stage #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    alu_dec_stage_if.slave   bus,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;

    localparam logic [2:0] AluAdd  = 3'b000;
    localparam logic [2:0] AluSub  = 3'b001;
    localparam logic [2:0] AluAnd  = 3'b010;
    localparam logic [2:0] AluOr   = 3'b011;
    localparam logic [2:0] AluSlt  = 3'b101;
    localparam logic [2:0] AluNone = 3'b111;

    typedef struct packed {
        logic [2:0] ctrl;
        logic       src_b;
        logic       ill;
    } ctl_t;

    ctl_t             dec;
    ctl_t             main_q;
    logic             out_valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             deliver;

    // Decode; anything not explicitly recognised falls through as illegal.
    always_comb begin
        dec.ctrl  = AluNone;
        dec.src_b = 1'b0;
        dec.ill   = 1'b1;
        case (bus.op)
            OpLoad, OpStore: begin
                dec.ctrl  = AluAdd;
                dec.src_b = 1'b1;
                dec.ill   = 1'b0;
            end
            OpBranch: begin
                if (bus.funct3 == 3'b000) begin
                    dec.ctrl = AluSub;
                    dec.ill  = 1'b0;
                end
            end
            OpReg, OpImm: begin
                case (bus.funct3)
                    3'b000: begin
                        // funct7b5 is an immediate bit for I-type, so only R-type subtracts.
                        dec.ctrl  = (bus.op == OpReg && bus.funct7b5) ? AluSub : AluAdd;
                        dec.src_b = (bus.op == OpImm);
                        dec.ill   = 1'b0;
                    end
                    3'b010: begin
                        dec.ctrl  = AluSlt;
                        dec.src_b = (bus.op == OpImm);
                        dec.ill   = 1'b0;
                    end
                    3'b110: begin
                        dec.ctrl  = AluOr;
                        dec.src_b = (bus.op == OpImm);
                        dec.ill   = 1'b0;
                    end
                    3'b111: begin
                        dec.ctrl  = AluAnd;
                        dec.src_b = (bus.op == OpImm);
                        dec.ill   = 1'b0;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign accept  = bus.in_valid & bus.in_ready;
    assign deliver = out_valid_q & bus.out_ready;

`ifdef ALU_DEC_SKID_EN
    ctl_t skid_q;
    logic skid_valid_q;

    // Skid only ever fills while main is full, so skid empty means room.
    assign bus.in_ready = ~skid_valid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            main_q       <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else begin
            if (skid_valid_q) begin
                // in_ready is low, so no accept can coincide with a skid drain.
                if (deliver) begin
                    main_q       <= skid_q;
                    skid_valid_q <= 1'b0;
                end
            end else if (accept) begin
                if (!out_valid_q || deliver) begin
                    main_q      <= dec;
                    out_valid_q <= 1'b1;
                end else begin
                    skid_q       <= dec;
                    skid_valid_q <= 1'b1;
                end
            end else if (deliver) begin
                out_valid_q <= 1'b0;
            end
            if (flush) begin
                out_valid_q  <= 1'b0;
                skid_valid_q <= 1'b0;
            end
        end
    end
`else
    assign bus.in_ready = ~out_valid_q | bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            main_q      <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            main_q      <= dec;
            out_valid_q <= 1'b1;
        end else if (deliver) begin
            out_valid_q <= 1'b0;
        end
    end
`endif

    // Counts deliveries, so a flush never touches it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (deliver && main_q.ill && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.alu_control = main_q.ctrl;
    assign bus.alu_src_b   = main_q.src_b;
    assign bus.illegal     = main_q.ill;
    assign illegal_cnt     = cnt_q;

endmodule

// File: doc/alu_dec_stage.md
# alu_dec_stage

Decode-to-execute control stage for the pipelined RISC-V core. It takes the opcode and function fields of a decoded instruction and produces the 3-bit ALU control word consumed by the execute-stage ALU, plus the B-operand select and an illegal flag. The result is registered behind a valid/ready handshake so the execute stage can stall it. It sits in the ID/EX boundary and drives the ALU's control input directly.

## Interface
- CNT_W, 16, width of saturating illegal-instruction counter
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  stage can accept this cycle
- op  in  7  instruction[6:0]
- funct3  in  3  instruction[14:12]
- funct7b5  in  1  instruction[30]
- flush  in  1  synchronous kill of all held entries
- out_valid  out  1  alu_control/alu_src_b/illegal valid
- out_ready  in  1  execute stage consumes this cycle
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt, 111 none (ALU yields 0)
- alu_src_b  out  1  1 = immediate, 0 = register
- illegal  out  1  unsupported encoding
- illegal_cnt  out  CNT_W  count of illegal entries delivered

## Operation
- Decode (combinational on inputs, registered on accept):
  - op 0000011 (lw), 0100011 (sw): add, alu_src_b=1.
  - op 1100011 (beq): sub, alu_src_b=0; funct3≠000 → illegal.
  - op 0110011 (R) / 0010011 (I): alu_src_b = (op==0010011). funct3 000 → sub if R and funct7b5, else add; 010 → slt; 110 → or; 111 → and; any other funct3 → illegal.
  - Any other op → illegal.
  - Illegal entries: alu_control=111, alu_src_b=0, illegal=1; still passed downstream in order.
- Accept when in_valid & in_ready; deliver when out_valid & out_ready.
- illegal_cnt increments on delivery of an entry with illegal=1; saturates at all-ones; never wraps.
- flush: next edge all entries invalid; an input presented in the flush cycle is dropped; illegal_cnt unaffected.
- Order strictly preserved; no entry duplicated or lost except by flush.

## Timing
- Reset (rst_n=0 at edge): out_valid=0, alu_control=000, alu_src_b=0, illegal=0, illegal_cnt=0, skid empty, in_ready=1 in the cycle after reset. Reset overrides flush and any handshake.
- Latency: accept at edge N → out_valid=1 after edge N, visible cycle N+1.
- Outputs stable while out_valid=1 and out_ready=0.
- Simultaneous deliver and accept: throughput one per cycle, no bubble.
- Reset mid-stall: held entries discarded.

## Configuration
- ALU_DEC_SKID_EN defined: main register plus one-entry skid buffer. in_ready is a register output (= skid empty), no combinational path from out_ready. When out stalls with main full and an input is accepted, it goes to skid; in_ready drops the next cycle. On drain, skid moves to main; in_ready returns the following cycle.
- Undefined: single register only; in_ready = ~out_valid | out_ready (combinational). Skid logic absent.
- Decode, flush, counter and reset behaviour identical in both builds.

## Test plan
- Reset with rst_n=0 for 2 cycles → out_valid=0, illegal_cnt=0, alu_control=000; in_ready=1 after release.
- Stream op=0110011 f3=000 f7b5=1, then f3=111, then op=0010011 f3=010, out_ready=1 → alu_control 001, 010, 101 on consecutive cycles, alu_src_b 0,0,1.
- op=1100011 f3=001, then op=1111111 → two deliveries illegal=1, alu_control=111; illegal_cnt=2.
- Hold out_ready=0 with in_valid=1 (skid build) → two entries accepted, in_ready=0 thereafter; release out_ready → both delivered in order, no loss.
- Assert flush with two entries held and in_valid=1 → next cycle out_valid=0, flushed-cycle input absent from output.
- Force CNT_W=2, deliver 5 illegal entries → illegal_cnt=3 (saturated).
